// File: rtl/gpio_bank_pkg.sv
// Shared definitions for the GPIO bank: register offsets, the IO address
// layout and a decode helper.
package gpio_bank_pkg;

  // Register offsets within a channel, held in the low nibble of the address.
  localparam logic [3:0] REG_IN   = 4'd0;  // RO   synchronised pins
  localparam logic [3:0] REG_OUT  = 4'd1;  // RW   output latch
  localparam logic [3:0] REG_DIR  = 4'd2;  // RW   1 = drive pad
  localparam logic [3:0] REG_SET  = 4'd3;  // WO   OUT |= d
  localparam logic [3:0] REG_CLR  = 4'd4;  // WO   OUT &= ~d
  localparam logic [3:0] REG_TGL  = 4'd5;  // WO   OUT ^= d
  localparam logic [3:0] REG_RISE = 4'd6;  // RW   rising-edge capture enable
  localparam logic [3:0] REG_FALL = 4'd7;  // RW   falling-edge capture enable
  localparam logic [3:0] REG_PEND = 4'd8;  // RW1C edge pending flags
  localparam logic [3:0] REG_IEN  = 4'd9;  // RW   interrupt enable mask

  // IO address layout: [15:8] bank, [7:4] channel, [3:0] register.
  typedef struct packed {
    logic [7:0] bank;
    logic [3:0] ch;
    logic [3:0] regsel;
  } gpio_addr_t;

  // Offsets above the last register are holes: they read 0 and ignore writes.
  function automatic logic reg_valid(input logic [3:0] r);
    return r <= REG_IEN;
  endfunction

endpackage

// File: rtl/gpio_bank_sync_edge.sv
// Per-channel input conditioning: two-flop synchroniser for asynchronous
// pads, a history flop, and single-cycle rise/fall pulses.
module gpio_sync_edge
  import gpio_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] hist_q;

  // Shift the pad value through meta -> sync -> history on every edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      meta_q <= '0;
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~hist_q;
  assign fall_o = ~sync_q & hist_q;

endmodule

// File: rtl/gpio_bank.sv
// Parametrised GPIO bank on the J1 IO bus: NCHAN ports of WIDTH bits with
// atomic set/clear/toggle, synchronised inputs, edge capture and a level irq.
// Pad tristates live in the enclosing top; this block only supplies
// pin_out/pin_oe and reads pin_in.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int         NCHAN = 4,
  parameter int         WIDTH = 8,
  parameter logic [7:0] BASE  = 8'h40
) (
  input  logic                   clk,
  input  logic                   resetq,
  input  logic                   io_rd,
  input  logic                   io_wr,
  input  logic [15:0]            io_addr,
  input  logic [15:0]            io_dout,
  output logic [15:0]            io_din,
  input  logic [NCHAN*WIDTH-1:0] pin_in,
  output logic [NCHAN*WIDTH-1:0] pin_out,
  output logic [NCHAN*WIDTH-1:0] pin_oe,
  output logic                   irq
);

  localparam logic [4:0] NCHAN_W = 5'(NCHAN);

  logic [15:0] addr_q;
  logic        wr_q;
  logic [15:0] dout_q;
  logic        irq_q;

  gpio_addr_t       acc;
  logic             sel_ok;
  logic [WIDTH-1:0] wdata;

  logic [NCHAN*WIDTH-1:0] rd_flat;
  logic [NCHAN-1:0]       irq_vec;
  logic [WIDTH-1:0]       rd_sel;

  // Capture the access address on any strobe; delay write strobe and data a
  // cycle so the commit uses the registered address.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      addr_q <= '0;
      wr_q   <= 1'b0;
      dout_q <= '0;
    end else begin
      if (io_rd || io_wr) begin
        addr_q <= io_addr;
      end
      wr_q   <= io_wr;
      dout_q <= io_dout;
    end
  end

  assign acc    = addr_q;
  assign sel_ok = (acc.bank == BASE) && ({1'b0, acc.ch} < NCHAN_W) &&
                  reg_valid(acc.regsel);
  assign wdata  = dout_q[WIDTH-1:0];

  // Data bits above WIDTH are don't-care on writes.
  if (WIDTH < 16) begin : g_dout_unused
    logic unused_dout_hi;
    assign unused_dout_hi = |dout_q[15:WIDTH];
  end

  for (genvar c = 0; c < NCHAN; c++) begin : g_ch
    logic [WIDTH-1:0] out_q,  out_d;
    logic [WIDTH-1:0] dir_q,  dir_d;
    logic [WIDTH-1:0] rien_q, rien_d;
    logic [WIDTH-1:0] fien_q, fien_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] ien_q,  ien_d;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] sync_s, edge_rise, edge_fall;
    logic [WIDTH-1:0] rd;
    logic             we;

    assign we = wr_q && sel_ok && (acc.ch == 4'(c));

    gpio_sync_edge #(.WIDTH(WIDTH)) u_sync (
      .clk    (clk),
      .resetq (resetq),
      .pin_i  (pin_in[c*WIDTH +: WIDTH]),
      .sync_o (sync_s),
      .rise_o (edge_rise),
      .fall_o (edge_fall)
    );

    // Next-state for the channel registers; SET/CLR/TGL act on the current
    // latch so there is no read-modify-write window.
    // NOTE: every variable gets a default at the top of the block, so paths
    // that skip an assignment hold the old value instead of inferring a latch.
    always_comb begin
      out_d  = out_q;
      dir_d  = dir_q;
      rien_d = rien_q;
      fien_d = fien_q;
      ien_d  = ien_q;
      w1c    = '0;
      if (we) begin
        case (acc.regsel)
          REG_OUT:  out_d  = wdata;
          REG_DIR:  dir_d  = wdata;
          REG_SET:  out_d  = out_q | wdata;
          REG_CLR:  out_d  = out_q & ~wdata;
          REG_TGL:  out_d  = out_q ^ wdata;
          REG_RISE: rien_d = wdata;
          REG_FALL: fien_d = wdata;
          REG_PEND: w1c    = wdata;
          REG_IEN:  ien_d  = wdata;
          default:  ;
        endcase
      end
      // New captures are OR-ed after the clear, so a same-cycle edge wins.
      pend_d = (pend_q & ~w1c) | (edge_rise & rien_q) | (edge_fall & fien_q);
    end

    // Channel register file.
    // NOTE: these small per-channel arrays are plain flops with async reset so
    // pins come up undriven; large storage arrays would not be reset this way.
    always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
        out_q  <= '0;
        dir_q  <= '0;
        rien_q <= '0;
        fien_q <= '0;
        pend_q <= '0;
        ien_q  <= '0;
      end else begin
        out_q  <= out_d;
        dir_q  <= dir_d;
        rien_q <= rien_d;
        fien_q <= fien_d;
        pend_q <= pend_d;
        ien_q  <= ien_d;
      end
    end

    // Per-channel read mux; write-only registers read back as zero.
    always_comb begin
      rd = '0;
      case (acc.regsel)
        REG_IN:   rd = sync_s;
        REG_OUT:  rd = out_q;
        REG_DIR:  rd = dir_q;
        REG_RISE: rd = rien_q;
        REG_FALL: rd = fien_q;
        REG_PEND: rd = pend_q;
        REG_IEN:  rd = ien_q;
        default:  rd = '0;
      endcase
    end

    assign rd_flat[c*WIDTH +: WIDTH] = rd;
    assign pin_out[c*WIDTH +: WIDTH] = out_q;
    assign pin_oe[c*WIDTH +: WIDTH]  = dir_q;
    assign irq_vec[c]                = |(pend_q & ien_q);
  end

  // Pick the addressed channel's read data.
  always_comb begin
    rd_sel = '0;
    for (int c = 0; c < NCHAN; c++) begin
      if (acc.ch == 4'(c)) begin
        rd_sel = rd_flat[c*WIDTH +: WIDTH];
      end
    end
  end

  assign io_din = sel_ok ? 16'(rd_sel) : 16'h0000;

  // Registered interrupt: level OR of enabled pending bits across channels.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |irq_vec;
    end
  end

  assign irq = irq_q;

endmodule
